// File: rtl/mips_rf_pkg.sv
// Shared register-file definitions: default widths, register count and reset data value.
package mips_rf_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  localparam int NREGS_DEF  = 2 ** ADDR_W_DEF;
  localparam int RESET_DATA = 0;

endpackage

// File: rtl/rd_wr_scoreboard.sv
// Per-register write scoreboard: pending bits, outstanding-write count, sticky stray write-back flag.
module rd_wr_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = ADDR_W + 1,
  parameter int NREGS  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_wreg,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic              skip,
  input  logic              flush,
  output logic [NREGS-1:0]  pending,
  output logic              wr_en,
  output logic [CNT_W-1:0]  pend_cnt,
  output logic              err_wb
);

  logic             claim;
  logic             commit_hit;
  logic             stray_wb;
  logic [NREGS-1:0] pend_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    commit_hit  = wb_valid && pending[wb_reg];
    stray_wb    = wb_valid && !pending[wb_reg] && !flush;
    // A pending destination may be reclaimed in the same cycle its write-back retires.
    issue_ready = !flush && (!pending[issue_wreg] || (wb_valid && (wb_reg == issue_wreg)));
    claim       = issue_valid && issue_ready;
    wr_en       = commit_hit && !skip;

    pend_nxt = pending;
    if (commit_hit) pend_nxt[wb_reg] = 1'b0;
    if (claim)      pend_nxt[issue_wreg] = 1'b1;
    if (flush)      pend_nxt = '0;

    if (flush) cnt_nxt = '0;
    else       cnt_nxt = pend_cnt + CNT_W'(claim) - CNT_W'(commit_hit);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      pend_cnt <= '0;
      err_wb   <= 1'b0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
      if (stray_wb) err_wb <= 1'b1;
    end
  end

endmodule

// File: rtl/rd_wr_sb_unit.sv
// Register read/write unit with write scoreboard; define RD_WR_SB_BYPASS_EN to forward
// same-cycle write-back data to the source read ports.
module rd_wr_sb_unit
  import mips_rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_wreg,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rreg1,
  input  logic [ADDR_W-1:0] rreg2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              src_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              skip,
  input  logic              flush,
  output logic [CNT_W-1:0]  pend_cnt,
  output logic              err_wb
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending;
  logic              wr_en;
  logic              byp1;
  logic              byp2;

  rd_wr_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .NREGS  (NREGS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_wreg  (issue_wreg),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .skip        (skip),
    .flush       (flush),
    .pending     (pending),
    .wr_en       (wr_en),
    .pend_cnt    (pend_cnt),
    .err_wb      (err_wb)
  );

  // NOTE: the array is reset because architectural registers must read zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= DATA_W'(RESET_DATA);
    end else if (wr_en) begin
      regs[wb_reg] <= wb_data;
    end
  end

  always_comb begin
`ifdef RD_WR_SB_BYPASS_EN
    byp1 = wb_valid && !skip && pending[wb_reg] && (wb_reg == rreg1);
    byp2 = wb_valid && !skip && pending[wb_reg] && (wb_reg == rreg2);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    rd1       = byp1 ? wb_data : regs[rreg1];
    rd2       = byp2 ? wb_data : regs[rreg2];
    src_ready = (!pending[rreg1] || byp1) && (!pending[rreg2] || byp2);
  end

endmodule

// File: tb/tb_rd_wr_sb_unit.sv
// Directed vector bench for rd_wr_sb_unit; expectations follow RD_WR_SB_BYPASS_EN when defined.
module tb_rd_wr_sb_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

`ifdef RD_WR_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_wreg;
  logic              issue_ready;
  logic [ADDR_W-1:0] rreg1, rreg2;
  logic [DATA_W-1:0] rd1, rd2;
  logic              src_ready;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              skip;
  logic              flush;
  logic [CNT_W-1:0]  pend_cnt;
  logic              err_wb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rd_wr_sb_unit dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_wreg  (issue_wreg),
    .issue_ready (issue_ready),
    .rreg1       (rreg1),
    .rreg2       (rreg2),
    .rd1         (rd1),
    .rd2         (rd2),
    .src_ready   (src_ready),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .skip        (skip),
    .flush       (flush),
    .pend_cnt    (pend_cnt),
    .err_wb      (err_wb)
  );

  typedef struct {
    logic              iv;
    logic [ADDR_W-1:0] iw;
    logic [ADDR_W-1:0] r1;
    logic [ADDR_W-1:0] r2;
    logic              wv;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wd;
    logic              sk;
    logic              fl;
    logic              e_ir;
    logic [DATA_W-1:0] e_rd1;
    logic [DATA_W-1:0] e_rd2;
    logic              e_sr;
    logic [CNT_W-1:0]  e_pc;
    logic              e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input int iw, input int r1, input int r2,
                     input logic wv, input int wr, input int wd, input logic sk, input logic fl,
                     input logic e_ir, input int e_rd1, input int e_rd2, input logic e_sr,
                     input int e_pc, input logic e_err);
    vec_t v;
    v.iv = iv; v.iw = ADDR_W'(iw); v.r1 = ADDR_W'(r1); v.r2 = ADDR_W'(r2);
    v.wv = wv; v.wr = ADDR_W'(wr); v.wd = DATA_W'(wd); v.sk = sk; v.fl = fl;
    v.e_ir = e_ir; v.e_rd1 = DATA_W'(e_rd1); v.e_rd2 = DATA_W'(e_rd2);
    v.e_sr = e_sr; v.e_pc = CNT_W'(e_pc); v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    issue_valid = 0; issue_wreg = '0; rreg1 = '0; rreg2 = '0;
    wb_valid = 0; wb_reg = '0; wb_data = '0; skip = 0; flush = 0;
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();

    // Each row: inputs for one cycle, then outputs expected before that cycle's clock edge.
    //   iv iw r1 r2  wv wr wd      sk fl   ir rd1     rd2     sr  pc err
    add(0, 0, 0, 1,   0, 0, 0,      0, 0,   1, 0,      0,      1,  0, 0);
    add(0, 0, 6, 7,   0, 0, 0,      0, 0,   1, 0,      0,      1,  0, 0);
    add(1, 3, 3, 0,   0, 0, 0,      0, 0,   1, 0,      0,      1,  0, 0);
    add(0, 0, 3, 0,   1, 3, 'h1234, 0, 0,   1, BYP ? 'h1234 : 0, 0, BYP, 1, 0);
    add(0, 0, 3, 0,   0, 0, 0,      0, 0,   1, 'h1234, 0,      1,  0, 0);
    add(1, 5, 5, 3,   0, 0, 0,      0, 0,   1, 0,      'h1234, 1,  0, 0);
    add(1, 5, 5, 3,   0, 0, 0,      0, 0,   0, 0,      'h1234, 0,  1, 0);
    add(1, 5, 5, 3,   1, 5, 'hBEEF, 0, 0,   1, BYP ? 'hBEEF : 0, 'h1234, BYP, 1, 0);
    add(0, 0, 5, 3,   0, 0, 0,      0, 0,   1, 'hBEEF, 'h1234, 0,  1, 0);
    add(0, 0, 5, 0,   1, 5, 0,      1, 0,   1, 'hBEEF, 0,      0,  1, 0);
    add(1, 2, 2, 0,   0, 0, 0,      0, 0,   1, 0,      0,      1,  0, 0);
    add(0, 0, 2, 0,   1, 2, 'hFFFF, 1, 0,   1, 0,      0,      0,  1, 0);
    add(0, 0, 2, 5,   0, 0, 0,      0, 0,   1, 0,      'hBEEF, 1,  0, 0);
    add(0, 0, 6, 0,   1, 6, 'h5555, 0, 0,   1, 0,      0,      1,  0, 0);
    add(0, 0, 6, 0,   0, 0, 0,      0, 0,   1, 0,      0,      1,  0, 1);
    add(1, 1, 0, 0,   0, 0, 0,      0, 0,   1, 0,      0,      1,  0, 1);
    add(1, 2, 0, 0,   0, 0, 0,      0, 0,   1, 0,      0,      1,  1, 1);
    add(1, 4, 0, 0,   0, 0, 0,      0, 0,   1, 0,      0,      1,  2, 1);
    add(1, 7, 1, 4,   0, 0, 0,      0, 1,   0, 0,      0,      0,  3, 1);
    add(0, 7, 7, 1,   0, 0, 0,      0, 0,   1, 0,      0,      1,  0, 1);
    add(1, 4, 0, 4,   0, 0, 0,      0, 0,   1, 0,      0,      1,  0, 1);
    add(0, 0, 0, 4,   1, 4, 'h00A5, 0, 0,   1, 0, BYP ? 'h00A5 : 0, BYP, 1, 1);
    add(0, 0, 0, 4,   0, 0, 0,      0, 0,   1, 0,      'h00A5, 1,  0, 1);
    add(1, 6, 6, 0,   0, 0, 0,      0, 0,   1, 0,      0,      1,  0, 1);
    add(0, 0, 6, 0,   1, 6, 'h7777, 0, 1,   0, BYP ? 'h7777 : 0, 0, BYP, 1, 1);
    add(0, 0, 6, 4,   0, 0, 0,      0, 0,   1, 'h7777, 'h00A5, 1, 0, 1);

    // Reset state: every register reads zero, nothing pending.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rreg1 = ADDR_W'(i); rreg2 = ADDR_W'(7 - i);
      #1;
      check($sformatf("reset_rd1_r%0d", i), 32'(rd1), 32'h0);
      check($sformatf("reset_rd2_r%0d", 7 - i), 32'(rd2), 32'h0);
    end
    check("reset_src_ready", 32'(src_ready), 32'h1);
    check("reset_issue_ready", 32'(issue_ready), 32'h1);
    check("reset_pend_cnt", 32'(pend_cnt), 32'h0);
    check("reset_err_wb", 32'(err_wb), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      issue_valid = vecs[k].iv; issue_wreg = vecs[k].iw;
      rreg1 = vecs[k].r1; rreg2 = vecs[k].r2;
      wb_valid = vecs[k].wv; wb_reg = vecs[k].wr; wb_data = vecs[k].wd;
      skip = vecs[k].sk; flush = vecs[k].fl;
      #1;
      check($sformatf("v%0d_issue_ready", k), 32'(issue_ready), 32'(vecs[k].e_ir));
      check($sformatf("v%0d_rd1", k), 32'(rd1), 32'(vecs[k].e_rd1));
      check($sformatf("v%0d_rd2", k), 32'(rd2), 32'(vecs[k].e_rd2));
      check($sformatf("v%0d_src_ready", k), 32'(src_ready), 32'(vecs[k].e_sr));
      check($sformatf("v%0d_pend_cnt", k), 32'(pend_cnt), 32'(vecs[k].e_pc));
      check($sformatf("v%0d_err_wb", k), 32'(err_wb), 32'(vecs[k].e_err));
    end

    // Fill all eight registers as pending: count saturates at NREGS, further claims refused.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_idle();
      issue_valid = 1; issue_wreg = ADDR_W'(i);
    end
    @(negedge clk);
    drive_idle();
    issue_valid = 1; issue_wreg = 3'd2;
    #1;
    check("full_pend_cnt", 32'(pend_cnt), 32'd8);
    check("full_issue_ready", 32'(issue_ready), 32'h0);
    rreg1 = 3'd4;
    #1;
    check("full_src_ready", 32'(src_ready), 32'h0);

    // Asynchronous reset mid-cycle clears pending, count, error flag and data at once.
    #2;
    rst = 1'b0;
    #1;
    check("midrst_pend_cnt", 32'(pend_cnt), 32'h0);
    check("midrst_err_wb", 32'(err_wb), 32'h0);
    check("midrst_rd1_r4", 32'(rd1), 32'h0);
    check("midrst_issue_ready", 32'(issue_ready), 32'h1);
    check("midrst_src_ready", 32'(src_ready), 32'h1);

    // A write-back outstanding from before reset is now stray and flags an error.
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    wb_valid = 1; wb_reg = 3'd4; wb_data = 16'h9999; rreg1 = 3'd4;
    @(negedge clk);
    drive_idle();
    rreg1 = 3'd4;
    #1;
    check("post_rst_err_wb", 32'(err_wb), 32'h1);
    check("post_rst_no_write", 32'(rd1), 32'h0);
    check("post_rst_pend_cnt", 32'(pend_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
